// File: rtl/serial_word_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits, optional even parity,
// delivered on a valid/ready output port with a sticky overrun flag.
module serial_word_receiver #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  input  logic             q_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             par_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] sh_in;
  logic [WIDTH-1:0] word;
  logic             dir_q;
  logic             dir_d;
  logic             done;
  logic             perr;

  assign sh_in = dir_q ? {sh[WIDTH-2:0], s_in}
                       : {s_in, sh[WIDTH-1:1]};
  assign busy  = (state != IDLE);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sh_d    = sh;
    dir_d   = dir_q;
    done    = 1'b0;
    word    = sh;
    perr    = 1'b0;
    if (enb) begin
      unique case (state)
        IDLE: begin
          if (s_in) begin
            state_d = SHIFT;
            dir_d   = dir;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          sh_d  = sh_in;
          cnt_d = cnt + 1'b1;
          if (cnt == LAST) begin
            cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
            end else begin
              state_d = IDLE;
              done    = 1'b1;
              word    = sh_in;
            end
          end
        end
        PARITY: begin
          state_d = IDLE;
          done    = 1'b1;
          perr    = (^sh) ^ s_in;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      dir_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sh    <= sh_d;
      dir_q <= dir_d;
    end
  end

  // A completing frame may replace a word that is consumed on the same edge.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      q       <= '0;
      q_valid <= 1'b0;
      par_err <= 1'b0;
      overrun <= 1'b0;
    end else if (done) begin
      if (!q_valid || q_ready) begin
        q       <= word;
        par_err <= perr;
        q_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (q_valid && q_ready) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Randomised self-checking bench for serial_word_receiver against a
// frame-level model of the output port.
module tb_serial_word_receiver;
  localparam int W = 4;
  localparam int P = 1;

  logic         clk = 1'b0;
  logic         reset_L;
  logic         enb;
  logic         dir;
  logic         s_in;
  logic         q_ready;
  logic [W-1:0] q;
  logic         q_valid;
  logic         par_err;
  logic         overrun;
  logic         busy;

  int errs = 0;
  int checks = 0;

  logic [W-1:0] exp_q;
  logic         exp_v;
  logic         exp_pe;
  logic         exp_ov;

  always #5 clk = ~clk;

  serial_word_receiver #(.WIDTH(W), .PARITY_EN(P)) dut (
    .clk(clk), .reset_L(reset_L), .enb(enb), .dir(dir),
    .s_in(s_in), .q_ready(q_ready), .q(q), .q_valid(q_valid),
    .par_err(par_err), .overrun(overrun), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q = '0; exp_v = 0; exp_pe = 0; exp_ov = 0;
  endtask

  task automatic model(input logic r, input logic last,
                       input logic [W-1:0] w, input logic pe);
    if (last) begin
      if (!exp_v || r) begin
        exp_q = w; exp_pe = pe; exp_v = 1'b1;
      end else begin
        exp_ov = 1'b1;
      end
    end else if (exp_v && r) begin
      exp_v = 1'b0;
    end
  endtask

  task automatic step(input logic e, input logic s, input logic r);
    enb = e; s_in = s; q_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic check_out(input string tag);
    check({tag, ".q"}, 32'(q), 32'(exp_q));
    check({tag, ".q_valid"}, 32'(q_valid), 32'(exp_v));
    check({tag, ".par_err"}, 32'(par_err), 32'(exp_pe));
    check({tag, ".overrun"}, 32'(overrun), 32'(exp_ov));
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, r);
      model(r, 1'b0, '0, 1'b0);
    end
  endtask

  // Serialise one frame; gap inserts enb=0 cycles carrying garbage.
  task automatic send_frame(input logic d_dir, input logic [W-1:0] d,
                            input logic p, input int gap,
                            input logic r_mid, input logic r_last,
                            input string tag);
    logic bits[$];
    logic pe;
    logic last;
    logic r;
    bits.push_back(1'b1);
    for (int i = 0; i < W; i++)
      bits.push_back(d_dir ? d[W-1-i] : d[i]);
    if (P != 0) bits.push_back(p);
    pe = (P != 0) ? ((^d) ^ p) : 1'b0;
    dir = d_dir;
    for (int i = 0; i < bits.size(); i++) begin
      last = (i == bits.size() - 1);
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          step(1'b0, 1'($urandom), r_mid);
          model(r_mid, 1'b0, '0, 1'b0);
        end
      end
      r = last ? r_last : r_mid;
      step(1'b1, bits[i], r);
      model(r, last, d, pe);
      if (i == 0) begin
        check({tag, ".busy_start"}, 32'(busy), 32'd1);
        dir = ~d_dir;
      end
    end
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    check_out(tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_L = 0; enb = 0; dir = 0; s_in = 0; q_ready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check_out("rst");
    reset_L = 1;
    idle(3, 1'b0);
    check("idle.busy", 32'(busy), 32'd0);

    send_frame(1'b1, 4'hB, 1'b1, 0, 1'b0, 1'b0, "msb");
    idle(1, 1'b1);
    check("msb.consume", 32'(q_valid), 32'd0);

    send_frame(1'b0, 4'hD, 1'b0, 0, 1'b0, 1'b0, "lsb");
    idle(1, 1'b1);
    check("lsb.consume", 32'(q_valid), 32'd0);

    send_frame(1'b1, 4'h3, 1'b0, 0, 1'b0, 1'b0, "ovr_a");
    send_frame(1'b0, 4'hA, 1'b0, 0, 1'b0, 1'b0, "ovr_b");
    check("ovr.q_kept", 32'(q), 32'h3);
    check("ovr.flag", 32'(overrun), 32'd1);

    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #2 reset_L = 0;
    #1;
    model_clear();
    check("amid.busy", 32'(busy), 32'd0);
    check_out("amid");
    @(posedge clk); #1;
    reset_L = 1;
    idle(4, 1'b0);
    check("post.busy", 32'(busy), 32'd0);
    check_out("post");

    send_frame(1'b1, 4'h5, 1'b0, 0, 1'b0, 1'b0, "cons_a");
    send_frame(1'b1, 4'h9, 1'b0, 0, 1'b0, 1'b1, "cons_b");
    check("cons.q", 32'(q), 32'h9);
    check("cons.ovr", 32'(overrun), 32'd0);
    idle(1, 1'b1);

    send_frame(1'b1, 4'h6, 1'b0, 1, 1'b0, 1'b0, "gate_m");
    idle(1, 1'b1);
    send_frame(1'b0, 4'h6, 1'b0, 2, 1'b0, 1'b0, "gate_l");
    idle(1, 1'b1);

    for (int n = 0; n < 100; n++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      send_frame(1'($urandom), d, ^d, $urandom_range(0, 1),
                 1'($urandom), 1'($urandom), "loop");
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        logic r;
        r = 1'($urandom);
        step(1'($urandom), 1'b0, r);
        model(r, 1'b0, '0, 1'b0);
      end
    end
    check_out("final");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
